// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and counter sizing.
package serial_adder_ctrl_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Bit-step counter width: $clog2(width), never less than one bit.
   function automatic int calc_cnt_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

   // Counter width for the default 8-bit configuration.
   localparam int CNT_W = calc_cnt_w(8);

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle between an operand source (master) and the serial adder (slave).
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (output start, a, b, ci, input busy, done, sum, cout);
   modport slave  (input start, a, b, ci, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Single-bit combinational full adder, reused once per bit step by the serial adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ ci;
   assign cout = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walked over the operands LSB first,
// carry held in a flip-flop between steps; sum/cout registered on completion.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   serial_adder_ctrl_if.slave bus
);

   localparam int                 CW       = calc_cnt_w(WIDTH);
   localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] ps_q, ps_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;
   logic             fa_s, fa_c;

   fa_cell u_fa (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .ci   (carry_q),
      .sum  (fa_s),
      .cout (fa_c)
   );

   // Next-state logic: accept in IDLE, one bit per cycle in RUN, one-cycle DONE pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      ps_d    = ps_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_sr_d  = bus.a;
               b_sr_d  = bus.b;
               carry_d = bus.ci;
               cnt_d   = '0;
               ps_d    = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // New sum bit enters at the MSB so that after WIDTH steps bit 0 is the LSB.
            ps_d            = ps_q >> 1;
            ps_d[WIDTH-1]   = fa_s;
            a_sr_d          = a_sr_q >> 1;
            b_sr_d          = b_sr_q >> 1;
            carry_d         = fa_c;
            cnt_d           = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
               sum_d   = ps_d;
               cout_d  = fa_c;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything and aborts any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         ps_q    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         ps_q    <= ps_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an 8-bit and a 1-bit instance share clk/rst.
// Stimulus pushes expected {sum, cout, done cycle}; negedge monitors pop on each done.
module tb_serial_adder_ctrl;

   typedef struct {
      logic [7:0] s;
      logic       c;
      int         cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q8[$];
   exp_t q1[$];

   serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
   serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance n edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present a start for the 8-bit unit in the current cycle. It is accepted at the
   // next edge; done appears WIDTH edges later, i.e. at cycle cyc+9.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] es, input logic ec);
      exp_t e;
      bus8.start = 1'b1;
      bus8.a     = a;
      bus8.b     = b;
      bus8.ci    = ci;
      e.s   = es;
      e.c   = ec;
      e.cyc = cyc + 9;
      q8.push_back(e);
   endtask

   // Monitor for the 8-bit unit.
   always @(negedge clk) begin
      if (!rst && bus8.done) begin
         if (q8.size() == 0) begin
            chk("done8_unexpected_qsize", q8.size(), 1);
         end else begin
            exp_t e;
            e = q8.pop_front();
            chk("sum8", bus8.sum, e.s);
            chk("cout8", bus8.cout, e.c);
            chk("done8_cycle", cyc, e.cyc);
         end
      end
   end

   // Monitor for the 1-bit unit.
   always @(negedge clk) begin
      if (!rst && bus1.done) begin
         if (q1.size() == 0) begin
            chk("done1_unexpected_qsize", q1.size(), 1);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("sum1", bus1.sum, e.s[0]);
            chk("cout1", bus1.cout, e.c);
            chk("done1_cycle", cyc, e.cyc);
         end
      end
   end

   // Back-to-back vectors: a, b, ci, expected sum, expected cout.
   logic [7:0] bb_a [4] = '{8'h12, 8'h80, 8'h7F, 8'hC3};
   logic [7:0] bb_b [4] = '{8'h34, 8'h80, 8'h00, 8'h5E};
   logic       bb_ci[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic [7:0] bb_s [4] = '{8'h46, 8'h01, 8'h80, 8'h21};
   logic       bb_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   // Full-adder truth table indexed by {a,b,ci}: {cout,sum}.
   logic [1:0] fa_tt[8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   initial begin
      rst        = 1'b1;
      bus8.start = 1'b0;
      bus8.a     = '0;
      bus8.b     = '0;
      bus8.ci    = 1'b0;
      bus1.start = 1'b0;
      bus1.a     = '0;
      bus1.b     = '0;
      bus1.ci    = 1'b0;
      tick(3);

      // Reset state
      chk("rst_busy8", bus8.busy, 0);
      chk("rst_done8", bus8.done, 0);
      chk("rst_sum8", bus8.sum, 0);
      chk("rst_cout8", bus8.cout, 0);
      chk("rst_busy1", bus1.busy, 0);
      chk("rst_sum1", bus1.sum, 0);
      rst = 1'b0;
      tick(2);

      // 5A + 3C: busy timing and result hold
      issue8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      tick(1);
      bus8.start = 1'b0;
      bus8.a     = 8'h00;
      chk("t1_busy_after_start", bus8.busy, 1);
      tick(8);
      chk("t1_busy_done_cycle", bus8.busy, 1);
      tick(1);
      chk("t1_busy_after_done", bus8.busy, 0);
      chk("t1_done_low", bus8.done, 0);
      chk("t1_sum_hold", bus8.sum, 8'h96);
      tick(2);

      // FF + 01 then FF + FF + 1, result holds through the next run
      issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      tick(1);
      bus8.start = 1'b0;
      tick(9);
      chk("t2a_sum_hold", bus8.sum, 8'h00);
      chk("t2a_cout_hold", bus8.cout, 1);
      issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      tick(1);
      bus8.start = 1'b0;
      tick(4);
      chk("t2b_sum_midrun", bus8.sum, 8'h00);
      tick(5);
      chk("t2b_sum_hold", bus8.sum, 8'hFF);
      chk("t2b_cout_hold", bus8.cout, 1);
      tick(1);

      // 10 + 20 with start held and a=FF during RUN/DONE; the held start is
      // accepted again only when the unit returns to IDLE (FF + 20 = 11F).
      issue8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
      tick(1);
      bus8.a = 8'hFF;
      tick(9);
      begin
         exp_t e;
         e.s   = 8'h1F;
         e.c   = 1'b1;
         e.cyc = cyc + 9;
         q8.push_back(e);
      end
      tick(1);
      bus8.start = 1'b0;
      tick(12);

      // AA + 55 aborted by reset at cnt==4, then 01 + 02
      issue8(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
      tick(1);
      bus8.start = 1'b0;
      tick(4);
      rst = 1'b1;
      void'(q8.pop_back());
      tick(1);
      rst = 1'b0;
      chk("t4_busy_after_rst", bus8.busy, 0);
      chk("t4_sum_after_rst", bus8.sum, 0);
      chk("t4_cout_after_rst", bus8.cout, 0);
      chk("t4_done_after_rst", bus8.done, 0);
      tick(12);
      issue8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
      tick(1);
      bus8.start = 1'b0;
      tick(11);

      // WIDTH=1 truth table; done two cycles after start is presented
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         exp_t       e;
         v = 3'(i);
         bus1.start = 1'b1;
         bus1.a     = v[2];
         bus1.b     = v[1];
         bus1.ci    = v[0];
         e.s   = {7'd0, fa_tt[i][0]};
         e.c   = fa_tt[i][1];
         e.cyc = cyc + 2;
         q1.push_back(e);
         tick(1);
         bus1.start = 1'b0;
         bus1.a     = ~v[2];
         bus1.b     = ~v[1];
         bus1.ci    = ~v[0];
         tick(3);
      end

      // Back-to-back with start held: one accepted add every 10 cycles; operands
      // are inverted between accepting cycles so only latched values matter.
      for (int k = 0; k < 4; k++) begin
         issue8(bb_a[k], bb_b[k], bb_ci[k], bb_s[k], bb_c[k]);
         tick(1);
         bus8.a  = ~bb_a[k];
         bus8.b  = ~bb_b[k];
         bus8.ci = ~bb_ci[k];
         tick(9);
      end
      bus8.start = 1'b0;
      tick(12);

      chk("q8_drained", q8.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
